// File: rtl/dsa_pkg.sv
// Shared arbiter types and sizing helpers.
// Provides arb_state_t and req_idx_w() for requester index widths.
package dsa_pkg;

    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // Index width for n requesters, never below 1 bit.
    function automatic int req_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wide_rd_arbiter_if.sv
// Requester-side bundle of the wide read arbiter.
// master: requester view (drives req_*); slave: arbiter view.
// Ports: req_valid/req_lock/req_addr0/req_addr1 in, req_ready,
//        rsp_valid, rsp_data0/rsp_data1 back to the requesters.
interface wide_rd_arbiter_if #(
    parameter int AW    = 10,
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_lock;
    logic [N_REQ*AW-1:0] req_addr0;
    logic [N_REQ*AW-1:0] req_addr1;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ-1:0]    rsp_valid;
    logic [31:0]         rsp_data0;
    logic [31:0]         rsp_data1;

    modport master (
        output req_valid, req_lock, req_addr0, req_addr1,
        input  req_ready, rsp_valid, rsp_data0, rsp_data1
    );

    modport slave (
        input  req_valid, req_lock, req_addr0, req_addr1,
        output req_ready, rsp_valid, rsp_data0, rsp_data1
    );
endinterface

// File: rtl/wide_rd_arbiter_rr_pick.sv
// Combinational rotate-priority encoder.
// Ports: i_valid (requests), i_ptr (top priority index),
//        o_gnt (one-hot), o_idx (grant index), o_any (any grant).
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_valid,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);
    // Scan from farthest to nearest so the requester closest to
    // i_ptr is the last (winning) assignment.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            int j;
            j = int'(i_ptr) + k;
            if (j >= N) j = j - N;
            if (i_valid[j]) begin
                o_gnt    = '0;
                o_gnt[j] = 1'b1;
                o_idx    = IW'(j);
                o_any    = 1'b1;
            end
        end
    end
endmodule

// File: rtl/wide_rd_arbiter.sv
// Round-robin arbiter for the two read ports of the wide image memory.
// Ports: clk, rst (async high), rq (requester bundle, slave),
//        mem_raddr0/1 out, mem_rdata0/1 in (1-cycle latency),
//        o_grant_count/o_stall_count (live only with WRARB_PERF_EN).
module wide_rd_arbiter
    import dsa_pkg::*;
#(
    parameter int AW       = 10,
    parameter int N_REQ    = 4,
    parameter int MAX_LOCK = 4
) (
    input  logic                clk,
    input  logic                rst,
    wide_rd_arbiter_if.slave    rq,
    output logic [AW-1:0]       mem_raddr0,
    input  logic [31:0]         mem_rdata0,
    output logic [AW-1:0]       mem_raddr1,
    input  logic [31:0]         mem_rdata1,
    output logic [31:0]         o_grant_count,
    output logic [31:0]         o_stall_count
);
    localparam int IW = req_idx_w(N_REQ);
    localparam int CW = $clog2(MAX_LOCK + 1);

    arb_state_t      r_state;
    arb_state_t      w_state_nx;
    logic [IW-1:0]   r_rr_ptr;
    logic [IW-1:0]   r_lock_owner;
    logic [IW-1:0]   w_owner_nx;
    logic [CW-1:0]   r_lock_cnt;
    logic [CW-1:0]   w_cnt_nx;
    logic [IW-1:0]   r_rsp_id;
    logic            r_rsp_pend;
    logic [AW-1:0]   r_addr0;
    logic [AW-1:0]   r_addr1;

    logic [N_REQ-1:0] w_pick_gnt;
    logic [IW-1:0]    w_pick_idx;
    logic             w_pick_any;
    logic [N_REQ-1:0] w_ready;
    logic [IW-1:0]    w_gidx;
    logic             w_acc;
    logic [AW-1:0]    w_gaddr0;
    logic [AW-1:0]    w_gaddr1;
    logic [N_REQ-1:0] w_rsp_valid;

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_pick (
        .i_valid (rq.req_valid),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    always_comb begin
        w_ready    = '0;
        w_gidx     = w_pick_idx;
        w_acc      = 1'b0;
        w_state_nx = r_state;
        w_owner_nx = r_lock_owner;
        w_cnt_nx   = r_lock_cnt;
        unique case (r_state)
            ARB_FREE: begin
                if (w_pick_any) begin
                    w_ready = w_pick_gnt;
                    w_acc   = 1'b1;
                    if (rq.req_lock[w_pick_idx] && (MAX_LOCK > 1)) begin
                        w_state_nx = ARB_LOCKED;
                        w_owner_nx = w_pick_idx;
                        w_cnt_nx   = CW'(1);
                    end
                end
            end
            ARB_LOCKED: begin
                w_gidx = r_lock_owner;
                if (rq.req_valid[r_lock_owner]) begin
                    w_ready[r_lock_owner] = 1'b1;
                    w_acc = 1'b1;
                    // This accept either ends the lock or bumps the count.
                    if (!rq.req_lock[r_lock_owner] ||
                        (r_lock_cnt >= CW'(MAX_LOCK - 1))) begin
                        w_state_nx = ARB_FREE;
                        w_cnt_nx   = '0;
                    end else begin
                        w_cnt_nx = r_lock_cnt + 1'b1;
                    end
                end else begin
                    // Owner vanished: nobody is served, unlock next cycle.
                    w_state_nx = ARB_FREE;
                    w_cnt_nx   = '0;
                end
            end
            default: begin
                w_state_nx = ARB_FREE;
            end
        endcase
    end

    assign w_gaddr0 = rq.req_addr0[w_gidx*AW +: AW];
    assign w_gaddr1 = rq.req_addr1[w_gidx*AW +: AW];

    // Hold the last granted address while idle.
    assign mem_raddr0 = w_acc ? w_gaddr0 : r_addr0;
    assign mem_raddr1 = w_acc ? w_gaddr1 : r_addr1;

    always_comb begin
        w_rsp_valid = '0;
        if (r_rsp_pend) w_rsp_valid[r_rsp_id] = 1'b1;
    end

    assign rq.req_ready = w_ready;
    assign rq.rsp_valid = w_rsp_valid;
    assign rq.rsp_data0 = mem_rdata0;
    assign rq.rsp_data1 = mem_rdata1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ARB_FREE;
            r_rr_ptr     <= '0;
            r_lock_owner <= '0;
            r_lock_cnt   <= '0;
            r_rsp_id     <= '0;
            r_rsp_pend   <= 1'b0;
            r_addr0      <= '0;
            r_addr1      <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_lock_owner <= w_owner_nx;
            r_lock_cnt   <= w_cnt_nx;
            r_rsp_pend   <= w_acc;
            if (w_acc) begin
                r_rsp_id <= w_gidx;
                r_addr0  <= w_gaddr0;
                r_addr1  <= w_gaddr1;
                r_rr_ptr <= (w_gidx == IW'(N_REQ - 1)) ? '0
                                                       : w_gidx + 1'b1;
            end
        end
    end

`ifdef WRARB_PERF_EN
    logic [31:0] r_grant_count;
    logic [31:0] r_stall_count;
    logic [31:0] w_stall_n;

    always_comb begin
        w_stall_n = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (rq.req_valid[i] && !w_ready[i]) w_stall_n = w_stall_n + 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_count <= '0;
            r_stall_count <= '0;
        end else begin
            r_grant_count <= r_grant_count + {31'd0, w_acc};
            r_stall_count <= r_stall_count + w_stall_n;
        end
    end

    assign o_grant_count = r_grant_count;
    assign o_stall_count = r_stall_count;
`else
    assign o_grant_count = 32'd0;
    assign o_stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_wide_rd_arbiter.sv
// Directed bench for wide_rd_arbiter (N_REQ=4, AW=10, MAX_LOCK=4).
// Counter expectations follow WRARB_PERF_EN when the bench is built.
module tb_wide_rd_arbiter;

    logic        clk;
    logic        rst;
    logic [9:0]  mem_raddr0;
    logic [9:0]  mem_raddr1;
    logic [31:0] mem_rdata0;
    logic [31:0] mem_rdata1;
    logic [31:0] o_grant_count;
    logic [31:0] o_stall_count;

    int          n_chk;
    int          n_err;
    logic [9:0]  a0 [4];
    logic [9:0]  a1 [4];
    logic [9:0]  last_a0;
    logic [9:0]  last_a1;
    logic [31:0] exp_g;
    logic [31:0] exp_s;

    wide_rd_arbiter_if #(.AW(10), .N_REQ(4)) rq ();

    wide_rd_arbiter #(
        .AW       (10),
        .N_REQ    (4),
        .MAX_LOCK (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rq            (rq),
        .mem_raddr0    (mem_raddr0),
        .mem_rdata0    (mem_rdata0),
        .mem_raddr1    (mem_raddr1),
        .mem_rdata1    (mem_rdata1),
        .o_grant_count (o_grant_count),
        .o_stall_count (o_stall_count)
    );

    always #5 clk = ~clk;

    // Memory: word content encodes port and address.
    always @(posedge clk) begin
        mem_rdata0 <= {16'hA000, 6'd0, mem_raddr0};
        mem_rdata1 <= {16'hB000, 6'd0, mem_raddr1};
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_perf();
`ifdef WRARB_PERF_EN
        chk("grant_cnt", o_grant_count, exp_g);
        chk("stall_cnt", o_stall_count, exp_s);
`else
        chk("grant_cnt_off", o_grant_count, 32'd0);
        chk("stall_cnt_off", o_stall_count, 32'd0);
`endif
    endtask

    // One cycle: drive v/l, check expected ready and response.
    task automatic step(input logic [3:0] v, input logic [3:0] l,
                        input logic [3:0] er, input logic [3:0] ers);
        int gi;
        logic [9:0] ea0;
        logic [9:0] ea1;
        rq.req_valid = v;
        rq.req_lock  = l;
        #3;
        gi = -1;
        for (int i = 0; i < 4; i++) if (er[i]) gi = i;
        ea0 = (gi >= 0) ? a0[gi] : last_a0;
        ea1 = (gi >= 0) ? a1[gi] : last_a1;
        chk("ready", {28'd0, rq.req_ready}, {28'd0, er});
        chk("rsp_valid", {28'd0, rq.rsp_valid}, {28'd0, ers});
        chk("raddr0", {22'd0, mem_raddr0}, {22'd0, ea0});
        chk("raddr1", {22'd0, mem_raddr1}, {22'd0, ea1});
        chk("rdata0", rq.rsp_data0, {16'hA000, 6'd0, last_a0});
        chk("rdata1", rq.rsp_data1, {16'hB000, 6'd0, last_a1});
        if ((v & er) != 4'd0) exp_g = exp_g + 1;
        exp_s = exp_s + 32'($countones(v & ~er));
        last_a0 = ea0;
        last_a1 = ea1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rq.req_valid = '0;
        rq.req_lock  = '0;
        rst = 1'b1;
        #3;
        chk("rst_rsp_valid", {28'd0, rq.rsp_valid}, 32'd0);
        chk("rst_raddr0", {22'd0, mem_raddr0}, 32'd0);
        exp_g   = 0;
        exp_s   = 0;
        last_a0 = '0;
        last_a1 = '0;
        chk_perf();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        exp_g = 0;
        exp_s = 0;
        last_a0 = '0;
        last_a1 = '0;
        clk = 1'b0;
        rst = 1'b0;
        a0[0] = 10'h010; a1[0] = 10'h011;
        a0[1] = 10'h020; a1[1] = 10'h021;
        a0[2] = 10'd5;   a1[2] = 10'd6;
        a0[3] = 10'h030; a1[3] = 10'h031;
        rq.req_valid = '0;
        rq.req_lock  = '0;
        rq.req_addr0 = {a0[3], a0[2], a0[1], a0[0]};
        rq.req_addr1 = {a1[3], a1[2], a1[1], a1[0]};
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        // Single requester 2, streaming 3 cycles.
        step(4'b0100, 4'b0000, 4'b0100, 4'b0000);
        step(4'b0100, 4'b0000, 4'b0100, 4'b0100);
        step(4'b0100, 4'b0000, 4'b0100, 4'b0100);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0100);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
        chk_perf();

        // All four valid, no lock: 0,1,2,3,0.
        do_reset();
        step(4'b1111, 4'b0000, 4'b0001, 4'b0000);
        step(4'b1111, 4'b0000, 4'b0010, 4'b0001);
        step(4'b1111, 4'b0000, 4'b0100, 4'b0010);
        step(4'b1111, 4'b0000, 4'b1000, 4'b0100);
        step(4'b1111, 4'b0000, 4'b0001, 4'b1000);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0001);
        chk_perf();

        // Requester 1 locks: 4 grants, then forced release to 2.
        step(4'b1111, 4'b0010, 4'b0010, 4'b0000);
        step(4'b1111, 4'b0010, 4'b0010, 4'b0010);
        step(4'b1111, 4'b0010, 4'b0010, 4'b0010);
        step(4'b1111, 4'b0010, 4'b0010, 4'b0010);
        step(4'b1111, 4'b0010, 4'b0100, 4'b0010);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0100);
        chk_perf();

        // Owner 3 drops valid: one dead cycle, then 0 wins.
        step(4'b1000, 4'b1000, 4'b1000, 4'b0000);
        step(4'b0001, 4'b1000, 4'b0000, 4'b1000);
        step(4'b0001, 4'b0000, 4'b0001, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0001);

        // Owner 2 drops lock but stays valid: served once more.
        step(4'b0100, 4'b0100, 4'b0100, 4'b0000);
        step(4'b0110, 4'b0000, 4'b0100, 4'b0100);
        step(4'b0110, 4'b0000, 4'b0010, 4'b0100);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0010);
        chk_perf();

        // Reset right after an accept drops the response.
        step(4'b0010, 4'b0000, 4'b0010, 4'b0000);
        do_reset();
        step(4'b0011, 4'b0000, 4'b0001, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0001);
        chk_perf();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
